// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Integrators use freq_to_inc to turn a target rate into a phase increment.
package clkgen_pkg;

   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } clkgenState_e;

   localparam int DEFAULT_ACC_W = 32;

   // inc = f_out * 2^ACC_W / f_ref, truncated toward zero
   function automatic logic [DEFAULT_ACC_W-1:0] freq_to_inc(input longint unsigned fRef,
                                                           input longint unsigned fOut);
      logic [95:0] scaled;
      logic [95:0] quotient;
      scaled   = {32'b0, fOut} << DEFAULT_ACC_W;
      quotient = scaled / {32'b0, fRef};
      return quotient[DEFAULT_ACC_W-1:0];
   endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One phase-accumulator channel: increment register, accumulator, and the
// registered tick (carry) and outclk (MSB) outputs.
module clkgen_channel
   import clkgen_pkg::*;
#(
   parameter int               ACC_W       = DEFAULT_ACC_W,
   parameter logic [ACC_W-1:0] DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic             load_i,
   input  logic [ACC_W-1:0] loadInc_i,
   output logic             tick_o,
   output logic             outclk_o
);

   logic [ACC_W-1:0] inc_q, inc_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             tick_q, tick_d;
   logic             outclk_q, outclk_d;
   logic [ACC_W:0]   sum;

   // A load restarts the channel from phase 0 and suppresses any carry this cycle
   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, inc_q};
      inc_d    = load_i ? loadInc_i : inc_q;
      acc_d    = sum[ACC_W-1:0];
      tick_d   = sum[ACC_W];
      outclk_d = sum[ACC_W-1];
      if (load_i || !enable_i) begin
         acc_d    = '0;
         tick_d   = 1'b0;
         outclk_d = 1'b0;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         inc_q    <= DEFAULT_INC;
         acc_q    <= '0;
         tick_q   <= 1'b0;
         outclk_q <= 1'b0;
      end else begin
         inc_q    <= inc_d;
         acc_q    <= acc_d;
         tick_q   <= tick_d;
         outclk_q <= outclk_d;
      end
   end

   assign tick_o   = tick_q;
   assign outclk_o = outclk_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with lock indication and a
// valid/ready reconfiguration port; every accepted write restarts the settle window.
module clk_enable_gen
   import clkgen_pkg::*;
#(
   parameter int               NUM_CH      = 2,
   parameter int               ACC_W       = DEFAULT_ACC_W,
   parameter logic [ACC_W-1:0] DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}},
   parameter int               LOCK_CYCLES = 16
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] outclk,
   output logic              locked
);

   localparam int             CNT_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   clkgenState_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             chInRange;

   assign cfg_ready = (state_q == LOCKED);
   assign locked    = (state_q == LOCKED);
   assign accept    = cfg_valid & cfg_ready;
   assign chInRange = ({1'b0, cfg_ch} < 4'(NUM_CH));

   // Out-of-range channel writes are consumed without disturbing the lock
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = LOCKED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOCKED: begin
            if (accept && chInRange) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = SETTLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= SETTLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : gCh
      logic loadCh;
      assign loadCh = accept & chInRange & (cfg_ch == 3'(i));

      clkgen_channel #(
         .ACC_W       (ACC_W),
         .DEFAULT_INC (DEFAULT_INC)
      ) uChannel (
         .refclk    (refclk),
         .rst       (rst),
         .enable_i  (ch_en[i]),
         .load_i    (loadCh),
         .loadInc_i (cfg_inc),
         .tick_o    (tick[i]),
         .outclk_o  (outclk[i])
      );
   end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: stimulus pushes per-edge expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clk_enable_gen;
   import clkgen_pkg::*;

   typedef struct {
      int         edgeNum;
      logic [1:0] tick;
      logic [1:0] outclk;
      logic       locked;
   } exp_t;

   logic        refclk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_ch;
   logic [31:0] cfg_inc;
   logic [1:0]  ch_en;
   logic [1:0]  tick;
   logic [1:0]  outclk;
   logic        locked;

   exp_t        sb[$];
   exp_t        monE;
   int          edgeCnt = 0;
   int          compared = 0;
   int          mismatched = 0;

   logic [31:0] expInc[2];
   int          origin[2];
   int          lockOrigin = 0;
   logic        lockedM = 1'b0;

   int          fracStart = 32'h3fff_ffff;
   int          fracEnd = 0;
   int          fracTicks = 0;
   int          lastFracTick = -1;
   int          minGap = 1000;

   clk_enable_gen #(
      .NUM_CH      (2),
      .ACC_W       (32),
      .DEFAULT_INC (32'h8000_0000),
      .LOCK_CYCLES (16)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .ch_en     (ch_en),
      .tick      (tick),
      .outclk    (outclk),
      .locked    (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   always @(posedge refclk) edgeCnt <= edgeCnt + 1;

   // Closed-form channel response j edges after a restart from phase 0
   function automatic void chanExp(input logic [31:0] inc, input int j,
                                   output logic t, output logic o);
      logic [63:0] p;
      logic [63:0] pPrev;
      if (j <= 0) begin
         t = 1'b0;
         o = 1'b0;
      end else begin
         p     = 64'(unsigned'(j)) * {32'b0, inc};
         pPrev = p - {32'b0, inc};
         t     = (p[63:32] != pPrev[63:32]);
         o     = p[31];
      end
   endfunction

   task automatic check1(input string name, input logic [1:0] act, input logic [1:0] req,
                         input int edgeNum);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s edge %0d: got %b expected %b", name, edgeNum, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      check1("tick", tick, e.tick, e.edgeNum);
      check1("outclk", outclk, e.outclk, e.edgeNum);
      check1("locked", {1'b0, locked}, {1'b0, e.locked}, e.edgeNum);
      check1("cfg_ready", {1'b0, cfg_ready}, {1'b0, e.locked}, e.edgeNum);
   endtask

   always @(negedge refclk) begin
      while (sb.size() > 0 && sb[0].edgeNum == edgeCnt) begin
         monE = sb.pop_front();
         checkOutput(monE);
      end
      if (edgeCnt >= fracStart && edgeCnt <= fracEnd && tick[1]) begin
         fracTicks++;
         if (lastFracTick >= 0 && (edgeCnt - lastFracTick) < minGap)
            minGap = edgeCnt - lastFracTick;
         lastFracTick = edgeCnt;
      end
   end

   // Drive one cycle of inputs and record what the next edge must produce
   task automatic applyStimulus(input logic rstV, input logic validV, input logic [2:0] chV,
                                input logic [31:0] incV, input logic [1:0] enV);
      exp_t e;
      int   target;
      logic acc;
      @(negedge refclk);
      rst       = rstV;
      cfg_valid = validV;
      cfg_ch    = chV;
      cfg_inc   = incV;
      ch_en     = enV;
      target    = edgeCnt + 1;
      e.edgeNum = target;
      e.tick    = 2'b00;
      e.outclk  = 2'b00;
      if (rstV) begin
         for (int i = 0; i < 2; i++) begin
            expInc[i] = 32'h8000_0000;
            origin[i] = target;
         end
         lockOrigin = target;
         lockedM    = 1'b0;
      end else begin
         acc = validV && lockedM;
         if (acc && chV < 3'd2) begin
            expInc[chV[0]] = incV;
            origin[chV[0]] = target;
            lockOrigin     = target;
            lockedM        = 1'b0;
         end else begin
            lockedM = ((target - lockOrigin) >= 16);
         end
         for (int i = 0; i < 2; i++) begin
            if (!enV[i]) origin[i] = target;
            chanExp(expInc[i], target - origin[i], e.tick[i], e.outclk[i]);
         end
      end
      e.locked = lockedM;
      sb.push_back(e);
   endtask

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = 3'd0;
      cfg_inc   = 32'h0;
      ch_en     = 2'b11;
      expInc[0] = 32'h8000_0000;
      expInc[1] = 32'h8000_0000;
      origin[0] = 0;
      origin[1] = 0;

      $display("[TB] reset and default 25 MHz run");
      repeat (2) applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 2'b11);
      repeat (40) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] reprogram ch1 to 1/8 rate");
      applyStimulus(1'b0, 1'b1, 3'd1, 32'h2000_0000, 2'b11);
      repeat (40) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] cfg_valid held through settle");
      repeat (18) applyStimulus(1'b0, 1'b1, 3'd1, freq_to_inc(50_000_000, 12_500_000), 2'b11);
      repeat (20) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] out-of-range channel write");
      applyStimulus(1'b0, 1'b1, 3'd5, 32'h1111_1111, 2'b11);
      repeat (6) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] fractional rate 1/3");
      applyStimulus(1'b0, 1'b1, 3'd1, 32'h5555_5555, 2'b11);
      fracStart = edgeCnt + 2;
      fracEnd   = edgeCnt + 3001;
      repeat (3000) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] ch0 disable and re-enable");
      repeat (10) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b10);
      repeat (6) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] write ch0 inc=0 on a carry edge");
      if (((edgeCnt + 1 - origin[0]) % 2) != 0)
         applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);
      applyStimulus(1'b0, 1'b1, 3'd0, 32'h0, 2'b11);
      repeat (20) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      $display("[TB] reset during settle with cfg_valid");
      applyStimulus(1'b0, 1'b1, 3'd1, 32'h2000_0000, 2'b11);
      repeat (5) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);
      applyStimulus(1'b1, 1'b1, 3'd0, 32'h1234_5678, 2'b11);
      repeat (24) applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 2'b11);

      repeat (4) @(negedge refclk);
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      compared++;
      if (fracTicks != 999 && fracTicks != 1000) begin
         mismatched++;
         $display("[TB] FAIL frac_count: got %0d ticks, expected 999 or 1000", fracTicks);
      end
      compared++;
      if (minGap < 3) begin
         mismatched++;
         $display("[TB] FAIL frac_gap: got min gap %0d, expected >= 3", minGap);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Multi-channel, runtime-reconfigurable fractional clock-enable generator driven from the board reference clock.
- Next generation of the fixed 50→25 MHz VGA clock source: arbitrary per-channel rates (pixel, CPU, PPU, APU enables) by phase accumulation, with a lock indication and a reconfiguration handshake.
- Outputs are single-cycle enables (tick) and approximate square waves (outclk), all synchronous to refclk.

Parameters:
- NUM_CH, 2, number of output channels (1..8)
- ACC_W, 32, phase accumulator width in bits
- DEFAULT_INC, 2**(ACC_W-1), reset increment for every channel (refclk/2, i.e. 25 MHz from 50 MHz)
- LOCK_CYCLES, 16, settle cycles before locked asserts (≥1)

Ports:
- refclk  in  1  sole clock
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  reconfiguration request
- cfg_ready  out  1  block accepts cfg this cycle
- cfg_ch  in  3  target channel index
- cfg_inc  in  ACC_W  new phase increment; f_out = f_refclk*inc/2^ACC_W
- ch_en  in  NUM_CH  per-channel run enable
- tick  out  NUM_CH  one-cycle pulse per output period
- outclk  out  NUM_CH  accumulator MSB, registered
- locked  out  1  all channels running on current config

Behaviour:
- Reset, sampled on refclk: every inc = DEFAULT_INC, every acc = 0, tick = 0, outclk = 0, locked = 0, cfg_ready = 0, state = SETTLE, cnt = 0. rst overrides every other input in the same cycle.
- Per channel, each edge with ch_en[i]=1: {carry, acc} <= acc + inc (ACC_W+1-bit add, wrap mod 2^ACC_W); tick[i] <= carry; outclk[i] <= new acc MSB.
- ch_en[i]=0: acc, tick and outclk forced to 0 next edge. Re-enabling restarts from phase 0.
- inc = 0 → channel static: tick never asserts, outclk stays 0.
- Latency with inc=2^(ACC_W-1), edges counted after rst deasserts:
  - edge1: acc=2^(ACC_W-1), outclk=1, tick=0
  - edge2: acc=0, outclk=0, tick=1
  - tick then repeats every 2 edges
- FSM states:
  - SETTLE: cnt++ each edge. When cnt==LOCK_CYCLES-1, go to LOCKED; locked=1 from that edge. After reset, locked first reads 1 after LOCK_CYCLES edges.
  - LOCKED: cfg_ready=1, locked=1.
- cfg_ready = (state==LOCKED), registered-state decode. No acceptance while settling.
- Accept = cfg_valid & cfg_ready.
  - cfg_ch < NUM_CH: on the next edge, inc[cfg_ch] <= cfg_inc, acc[cfg_ch] <= 0, tick[cfg_ch] <= 0, state <= SETTLE, cnt <= 0. locked and cfg_ready read 0 from that edge.
  - Other channels continue undisturbed.
- Accept with cfg_ch >= NUM_CH: request consumed, no state change, locked stays 1.
- cfg_valid while cfg_ready=0 has no effect; the requester holds it until accepted.
- Accept in the same cycle as a carry on the target channel: the write wins, and tick on that channel is 0.
- rst mid-settle or mid-operation: full return to reset values, including inc = DEFAULT_INC.

Decomposition:
- Shared package clkgen_pkg holds:
  - state enum {SETTLE, LOCKED}
  - ACC_W default constant
  - function freq_to_inc(f_ref, f_out) for bench and integrators
- One sub-module, clkgen_channel: accumulator, carry, tick/outclk registers and per-channel inc register with load/clear.
- Instantiated NUM_CH times in a generate loop.
- FSM, cnt and cfg decode live in the top.

Test Plan:
- Reset then run 40 edges, NUM_CH=2, ACC_W=32 → both channels: tick on edges 2,4,6…; outclk toggles each edge starting 1; locked=0 through edge 15, 1 at edge 16; cfg_ready mirrors locked.
- After lock, write ch1 inc=0x2000_0000 → cfg_ready/locked drop next edge and re-assert 16 edges later. ch1 ticks every 8 edges from its restart; ch0 tick cadence unbroken.
- Fractional rate: inc=0x5555_5555 for 3000 edges → exactly 999 or 1000 ticks, never two ticks fewer than 3 edges apart.
- Handshake: cfg_valid held high during SETTLE → no acceptance until locked; exactly one write on the first cycle cfg_ready=1. cfg_ch=5 when locked → no relock, locked stays 1.
- ch_en[0]=0 for 10 edges → tick[0]=outclk[0]=0. Re-enable → first tick 2 edges later (inc=2^31).
- rst asserted together with cfg_valid mid-settle → all outputs 0 next edge; incs back to 0x8000_0000; relock after 16 edges.
